// File: rtl/capp_pkg.sv
// Shared CAPP constants and the response resolver state encoding,
// common to the compare stage, the cell array and the resolver.
package capp_pkg;

  localparam int CAPP_WORDS = 100;
  localparam int CAPP_IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } resolver_state_e;

endpackage

// File: rtl/capp_priority_encoder.sv
// Combinational lowest-set-bit priority encoder over the CAPP tag vector.
// The index is 0 when nothing is set.
module capp_priority_encoder
  import capp_pkg::*;
#(
  parameter int WORDS = CAPP_WORDS,
  parameter int IDX_W = CAPP_IDX_W
) (
  input  logic [WORDS-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    index = {IDX_W{1'b0}};
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end else begin
        found = found;
        index = index;
      end
    end
  end

endmodule

// File: rtl/response_resolver.sv
// Latches CAPP responders into a tag register and enumerates them in
// ascending order over a valid/ready stream. Optional: RESOLVER_COUNT_EN.
module response_resolver
  import capp_pkg::*;
#(
  parameter int WORDS = CAPP_WORDS,
  parameter int IDX_W = CAPP_IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORDS-1:0]   mismatch_lines,
  input  logic               capture,
  input  logic               tag_and,
  input  logic               abort,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDX_W-1:0]   resp_index,
  output logic               some_responder,
  output logic               busy,
  output logic               done,
  output logic [IDX_W:0]     responder_count
);

  resolver_state_e  state_r, state_nxt_s;
  logic [WORDS-1:0] tag_r, tag_nxt_s, capture_tag_s, clear_mask_s;
  logic             found_s;
  logic [IDX_W-1:0] first_idx_s;

  capp_priority_encoder #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_penc (
    .req   (tag_r),
    .found (found_s),
    .index (first_idx_s)
  );

  // Tag value that a capture edge would load
  always_comb begin
    if (tag_and) begin
      capture_tag_s = tag_r & ~mismatch_lines;
    end else begin
      capture_tag_s = ~mismatch_lines;
    end
    clear_mask_s = {{(WORDS-1){1'b0}}, 1'b1} << first_idx_s;
  end

  // Next-state and tag update; abort takes precedence over a handshake
  always_comb begin
    state_nxt_s = state_r;
    tag_nxt_s   = tag_r;
    case (state_r)
      IDLE: begin
        if (capture) begin
          state_nxt_s = SCAN;
          tag_nxt_s   = capture_tag_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (!found_s) begin
          state_nxt_s = FINISH;
        end else if (resp_ready) begin
          tag_nxt_s = tag_r & ~clear_mask_s;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and tag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      tag_r   <= {WORDS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      tag_r   <= tag_nxt_s;
    end
  end

  assign resp_valid     = (state_r == SCAN) && found_s;
  assign resp_index     = first_idx_s;
  assign some_responder = |tag_r;
  assign busy           = (state_r != IDLE);
  assign done           = (state_r == FINISH) && !abort;

`ifdef RESOLVER_COUNT_EN
  logic [IDX_W:0] count_r, count_nxt_s;

  // Popcount of the freshly captured tag value
  always_comb begin
    count_nxt_s = {(IDX_W+1){1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      count_nxt_s = count_nxt_s + {{IDX_W{1'b0}}, capture_tag_s[i]};
    end
  end

  // Count is frozen between captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {(IDX_W+1){1'b0}};
    end else if ((state_r == IDLE) && capture) begin
      count_r <= count_nxt_s;
    end else begin
      count_r <= count_r;
    end
  end

  assign responder_count = count_r;
`else
  assign responder_count = {(IDX_W+1){1'b0}};
`endif

endmodule

// File: tb/tb_response_resolver.sv
// Directed self-checking bench for response_resolver.
// Count expectations follow RESOLVER_COUNT_EN.
module tb_response_resolver;
  import capp_pkg::*;

`ifdef RESOLVER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CAPP_WORDS-1:0] mismatch_lines;
  logic                  capture, tag_and, abort, resp_ready;
  logic                  resp_valid, some_responder, busy, done;
  logic [CAPP_IDX_W-1:0] resp_index;
  logic [CAPP_IDX_W:0]   responder_count;

  int total = 0;
  int bad   = 0;

  response_resolver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mismatch_lines  (mismatch_lines),
    .capture         (capture),
    .tag_and         (tag_and),
    .abort           (abort),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_index      (resp_index),
    .some_responder  (some_responder),
    .busy            (busy),
    .done            (done),
    .responder_count (responder_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_n = 1'b0; mismatch_lines = '1; capture = 1'b0; tag_and = 1'b0;
    abort = 1'b0; resp_ready = 1'b0;
    #12;
    chk("rst_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // 1: reset mid-SCAN, then zero-responder capture
    mismatch_lines = '1; mismatch_lines[1] = 1'b0; mismatch_lines[2] = 1'b0;
    capture = 1'b1;
    step();
    capture = 1'b0;
    chk("t1_scan_busy", busy, 1);
    chk("t1_scan_idx", resp_index, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", resp_valid, 0);
    chk("t1_rst_idx", resp_index, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_some", some_responder, 0);
    chk("t1_rst_done", done, 0);
    chk("t1_rst_cnt", responder_count, 0);
    rst_n = 1'b1;
    step();
    chk("t1_no_done", done, 0);
    mismatch_lines = '1; capture = 1'b1;
    step();
    capture = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_valid", resp_valid, 0);
    chk("t1_done_early", done, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_valid_fin", resp_valid, 0);
    step();
    chk("t1_done_once", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_cnt", responder_count, 0);

    // 2: streaming enumeration with ready held high
    mismatch_lines = '1;
    mismatch_lines[3] = 1'b0; mismatch_lines[17] = 1'b0; mismatch_lines[99] = 1'b0;
    resp_ready = 1'b1; capture = 1'b1;
    step();
    capture = 1'b0;
    chk("t2_v0", resp_valid, 1);
    chk("t2_i0", resp_index, 3);
    chk("t2_cnt", responder_count, cnt_exp(3));
    step();
    chk("t2_i1", resp_index, 17);
    step();
    chk("t2_i2", resp_index, 99);
    chk("t2_v2", resp_valid, 1);
    step();
    chk("t2_empty", resp_valid, 0);
    chk("t2_not_done", done, 0);
    step();
    chk("t2_done", done, 1);
    step();
    chk("t2_idle", busy, 0);
    chk("t2_cnt_hold", responder_count, cnt_exp(3));

    // tag_and after a completed scan yields zero responders
    mismatch_lines = '0; tag_and = 1'b1; capture = 1'b1;
    step();
    capture = 1'b0; tag_and = 1'b0;
    chk("t2b_valid", resp_valid, 0);
    chk("t2b_cnt", responder_count, 0);
    step();
    chk("t2b_done", done, 1);
    step();

    // 3: backpressure
    resp_ready = 1'b0;
    mismatch_lines = '1; mismatch_lines[5] = 1'b0; mismatch_lines[6] = 1'b0;
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_idx", resp_index, 5);
      chk("t3_stall_valid", resp_valid, 1);
      if (i < 3) step();
    end
    resp_ready = 1'b1;
    step();
    chk("t3_next", resp_index, 6);
    step();
    chk("t3_empty", resp_valid, 0);
    step();
    chk("t3_done", done, 1);
    step();

    // 4: multi-pass refinement
    resp_ready = 1'b0;
    mismatch_lines = '1;
    mismatch_lines[2] = 1'b0; mismatch_lines[4] = 1'b0; mismatch_lines[8] = 1'b0;
    capture = 1'b1;
    step();
    capture = 1'b0;
    chk("t4_first", resp_index, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_idle", busy, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_retained", some_responder, 1);
    mismatch_lines = '1;
    mismatch_lines[4] = 1'b0; mismatch_lines[8] = 1'b0; mismatch_lines[9] = 1'b0;
    tag_and = 1'b1; capture = 1'b1;
    step();
    capture = 1'b0; tag_and = 1'b0; resp_ready = 1'b1;
    chk("t4_i0", resp_index, 4);
    chk("t4_cnt", responder_count, cnt_exp(2));
    step();
    chk("t4_i1", resp_index, 8);
    step();
    chk("t4_end", resp_valid, 0);
    step();
    chk("t4_done", done, 1);
    step();
    chk("t4_some", some_responder, 0);

    // 5: ignored capture in SCAN, abort beats handshake
    resp_ready = 1'b0;
    mismatch_lines = '1; mismatch_lines[10] = 1'b0; mismatch_lines[20] = 1'b0;
    capture = 1'b1;
    step();
    mismatch_lines = '1;
    step();
    capture = 1'b0;
    chk("t5_ign_idx", resp_index, 10);
    chk("t5_ign_valid", resp_valid, 1);
    chk("t5_ign_cnt", responder_count, cnt_exp(2));
    abort = 1'b1; resp_ready = 1'b1;
    step();
    abort = 1'b0; resp_ready = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_valid", resp_valid, 0);
    chk("t5_bit10", resp_index, 10);
    chk("t5_some", some_responder, 1);
    chk("t5_no_done", done, 0);
    step();
    chk("t5_no_done2", done, 0);

    // 6: fifty responders
    mismatch_lines = {{50{1'b1}}, {50{1'b0}}};
    capture = 1'b1;
    step();
    capture = 1'b0;
    chk("t6_idx", resp_index, 0);
    chk("t6_cnt", responder_count, cnt_exp(50));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/response_resolver.md
Name: response_resolver

Overview:
- Receiving end of the search path. The compare stage drives search lines into the cell array, and the array returns per-word mismatch lines to this block.
- Latches the responders into a tag register, where responder = mismatch line low.
- Enumerates the tagged words in ascending index order over a valid/ready stream, so the controller can read or write them one at a time.
- Reports completion, and optionally the responder count.

Parameters:
- WORDS, 100, number of CAPP words and mismatch lines.
- IDX_W, 7, width of the word index; must satisfy 2**IDX_W >= WORDS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mismatch_lines  input  WORDS  per-word mismatch; 0 = word matched.
- capture  input  1  one-cycle request to latch responders; honoured only in IDLE.
- tag_and  input  1  sampled with capture. 0: tag = ~mismatch_lines. 1: tag = tag & ~mismatch_lines (multi-pass search).
- abort  input  1  ends enumeration and returns to IDLE.
- resp_valid  output  1  resp_index holds a tagged word.
- resp_ready  input  1  consumer accepts resp_index.
- resp_index  output  IDX_W  lowest-numbered tagged word.
- some_responder  output  1  tag register non-zero (any state).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when enumeration completes.
- responder_count  output  IDX_W+1  popcount of tags at capture; 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, tag = 0.
  - resp_valid = 0, resp_index = 0, done = 0, busy = 0, some_responder = 0, responder_count = 0.
  - Reset mid-SCAN discards all tags; no done pulse is produced.
- States: IDLE, SCAN, FINISH.
- IDLE:
  - capture=1 loads the tag register per tag_and on that edge and moves to SCAN.
  - capture outside IDLE is ignored; tags are not modified.
- SCAN:
  - resp_valid = |tag. resp_index = priority encode of tag (lowest set bit), decoded directly from the tag register with no extra register stage.
  - First index is visible the cycle after capture (latency 1).
  - On resp_valid & resp_ready: the bit at resp_index clears on that edge, and the next index is presented the following cycle. Sustained throughput is one word per cycle when ready is held high.
  - resp_index stays stable while resp_valid=1 and resp_ready=0.
  - When tag == 0 (including zero responders at capture) -> FINISH.
- FINISH: done = 1 for exactly one cycle, then -> IDLE. resp_valid = 0.
- abort in SCAN or FINISH:
  - Next state is IDLE; no done pulse.
  - Remaining tags are retained, so a later tag_and capture can refine them.
  - abort wins over a same-cycle handshake: the tag bit is not cleared.
- Enumeration empties the tag register, so tag_and after a completed scan yields zero responders.
- resp_index must never exceed WORDS-1. Unused encoder inputs above WORDS are treated as 0.
- mismatch_lines is sampled only on the capture edge; it may change freely otherwise.

Optional Feature:
- Macro RESOLVER_COUNT_EN.
- Defined:
  - responder_count is registered on the capture edge with popcount(new tag value).
  - It holds until the next capture or reset and does not decrement during enumeration.
- Undefined: the popcount logic is absent and responder_count is tied to 0.

Decomposition:
- Shared package capp_pkg:
  - CAPP_WORDS = 100, CAPP_IDX_W = 7.
  - resolver state enum {IDLE, SCAN, FINISH}.
  - These constants are shared with the compare stage and the array.
- One sub-module, capp_priority_encoder:
  - Parameterised WORDS/IDX_W.
  - Inputs: request vector. Outputs: found flag and lowest-set index.
  - Purely combinational, instantiated once.

Test Plan:
1. Reset and first capture.
   - Stimulus: reset asserted mid-SCAN, then released; capture with mismatch all 1s.
   - Required: all outputs 0 immediately on reset; after capture, SCAN then FINISH; done pulses 1 cycle after SCAN entry; resp_valid never 1; responder_count = 0.
2. Streaming enumeration.
   - Stimulus: mismatch 0 at words 3, 17, 99; resp_ready held 1.
   - Required: resp_index 3, 17, 99 on consecutive cycles; then done; responder_count = 3 with RESOLVER_COUNT_EN.
3. Backpressure.
   - Stimulus: responders 5 and 6; resp_ready low 4 cycles, then high.
   - Required: resp_index stable at 5 while stalled; 6 on the cycle after acceptance.
4. Multi-pass refinement.
   - Stimulus: capture tag_and=0 with responders {2, 4, 8}; abort immediately; capture tag_and=1 with responders {4, 8, 9}.
   - Required: enumeration yields 4, 8 only.
5. Ignored capture and abort precedence.
   - Stimulus: capture pulse during SCAN; abort together with resp_valid & resp_ready at index 10.
   - Required: capture has no effect on tags; state goes to IDLE; bit 10 stays set (some_responder = 1); no done pulse.
6. Compile-out check.
   - Stimulus: build without RESOLVER_COUNT_EN; capture with 50 responders.
   - Required: responder_count = 0; all other behaviour identical.
